// File: rtl/div_pkg.sv
// Shared definitions for the sequential divide unit: FSM encoding and the
// fixed widths/constants used by the divider and its bench.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int          DIV_WIDTH     = 16;
    localparam int          DIV_ITERS     = 16;
    localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups with a
// second lookahead level generating the group carries.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        pg,
    output logic        gg
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] carry;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_c;

    assign p = a ^ b;
    assign g = a & b;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            localparam int B = 4 * gi;

            assign grp_p[gi] = p[B+3] & p[B+2] & p[B+1] & p[B];
            assign grp_g[gi] = g[B+3]
                             | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);

            // Carries inside the group are fully expanded from the group carry-in.
            assign carry[B]   = grp_c[gi];
            assign carry[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign carry[B+2] = g[B+1] | (p[B+1] & g[B])
                              | (p[B+1] & p[B] & grp_c[gi]);
            assign carry[B+3] = g[B+2] | (p[B+2] & g[B+1])
                              | (p[B+2] & p[B+1] & g[B])
                              | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
        end
    endgenerate

    assign grp_c[0] = cin;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & cin);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & cin);

    assign pg   = &grp_p;
    assign gg   = grp_g[3]
                | (grp_p[3] & grp_g[2])
                | (grp_p[3] & grp_p[2] & grp_g[1])
                | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    assign cout = gg | (pg & cin);
    assign sum  = p ^ carry;

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle on a
// carry-lookahead adder, start/done handshake, results held until the next op.
module seq_divider_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state_reg, state_next;
    logic [3:0]       count_reg, count_next;
    logic [WIDTH:0]   r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic             dz_reg, dz_next;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] trial;
    logic             trial_cout;
    logic             trial_ok;
    logic [WIDTH:0]   r_iter;
    logic [WIDTH-1:0] q_iter;
    logic             cla_pg;
    logic             cla_gg;
    logic             unused_cla;

    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    // Subtraction as A + ~B + 1; carry-out high means no borrow.
    cla_16bit u_sub (
        .a    (r_shift[WIDTH-1:0]),
        .b    (~divisor_reg),
        .cin  (1'b1),
        .sum  (trial),
        .cout (trial_cout),
        .pg   (cla_pg),
        .gg   (cla_gg)
    );

    assign unused_cla = cla_pg & cla_gg;

    // Bit 16 of the shifted remainder means it already exceeds any divisor.
    assign trial_ok = r_shift[WIDTH] | trial_cout;
    assign r_iter   = trial_ok ? {1'b0, trial} : r_shift;
    assign q_iter   = {q_reg[WIDTH-2:0], trial_ok};

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        r_next       = r_reg;
        q_next       = q_reg;
        divisor_next = divisor_reg;
        quot_next    = quot_reg;
        rem_next     = rem_reg;
        dz_next      = dz_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    divisor_next = divisor;
                    if (divisor == '0) begin
                        state_next = DONE;
                        quot_next  = DIV_ZERO_QUOT;
                        rem_next   = dividend;
                        dz_next    = 1'b1;
                    end else begin
                        state_next = RUN;
                        count_next = '0;
                        r_next     = '0;
                        q_next     = dividend;
                    end
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                r_next     = r_iter;
                q_next     = q_iter;
                count_next = count_reg + 4'd1;
                if (count_reg == 4'(DIV_ITERS - 1)) begin
                    state_next = DONE;
                    quot_next  = q_iter;
                    rem_next   = r_iter[WIDTH-1:0];
                    dz_next    = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            divisor_reg <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            dz_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            r_reg       <= r_next;
            q_reg       <= q_next;
            divisor_reg <= divisor_next;
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
            dz_reg      <= dz_next;
        end
    end

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed bench for seq_divider_16bit: expected results queued at start,
// popped and checked when done pulses.
module tb_seq_divider_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   since_start = 0;
    int   busy_cnt = 0;

    seq_divider_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        since_start++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    // Drive start at the current negedge, queue the expected result, release
    // start after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        dividend    = 16'hDEAD;
        divisor     = 16'hBEEF;
        since_start = 0;
        busy_cnt    = (busy === 1'b1) ? 1 : 0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input int exp_busy);
        exp_t e;
        while (done !== 1'b1 && since_start < 40) tick();
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_latency"}, since_start, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, e.q});
            check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, e.r});
            check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dz});
        end
        $display("op %s: q=%0d r=%0d dz=%0b latency=%0d", tag, quotient, remainder,
                 div_by_zero, since_start);
    endtask

    initial begin
        int done_seen;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", {16'd0, quotient}, 32'd0);
        check("reset_remainder", {16'd0, remainder}, 32'd0);
        check("reset_dz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with one-cycle start, then pulse width and result hold.
        start_op(16'd100, 16'd7);
        check("d100_busy_after_accept", {31'd0, busy}, 32'd1);
        wait_result("d100_7", 16, 16);
        tick();
        check("d100_done_one_cycle", {31'd0, done}, 32'd0);
        repeat (3) tick();
        check("d100_hold_quotient", {16'd0, quotient}, 32'd14);
        check("d100_hold_remainder", {16'd0, remainder}, 32'd2);

        start_op(16'hFFFF, 16'h8001);
        wait_result("ffff_8001", 16, 16);
        tick();
        start_op(16'hFFFF, 16'h0001);
        wait_result("ffff_1", 16, 16);
        tick();

        // Divide by zero completes the cycle after start; next op clears the flag.
        start_op(16'd5, 16'd0);
        wait_result("d5_0", 0, 0);
        tick();
        start_op(16'd9, 16'd3);
        wait_result("d9_3", 16, 16);
        tick();

        // Back-to-back: new start accepted in the DONE cycle, no idle bubble.
        start_op(16'd3, 16'd10);
        wait_result("d3_10", 16, 16);
        start_op(16'hFFFF, 16'hFFFF);
        check("b2b_busy_no_bubble", {31'd0, busy}, 32'd1);
        wait_result("b2b_ffff_ffff", 16, 16);
        tick();

        // Start during RUN must be ignored.
        start_op(16'd200, 16'd9);
        repeat (5) tick();
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        tick();
        start    = 1'b0;
        wait_result("ignore_start_200_9", 16, 16);
        tick();
        check("ignore_start_no_restart", {31'd0, busy}, 32'd0);
        tick();

        // Reset mid-operation aborts without a done pulse.
        start_op(16'd1000, 16'd3);
        while (since_start < 8) tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", {16'd0, quotient}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        check("abort_dz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        void'(sb.pop_front());
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        $display("op abort_1000_3: reset at iteration 8, done pulses afterwards=%0d", done_seen);

        start_op(16'd1000, 16'd3);
        wait_result("d1000_3", 16, 16);
        tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
